acq_frame_sequencer: RTL

- Top-level acquisition scheduler for the APES front-end counting and readout path.
- Runs a repeating frame: clear the counters, integrate for a fixed window, freeze, and hand the frozen counts to the rocket counts-readout shifter.
- Waits for readout completion and guards it with a watchdog so a silent rocket cannot stall acquisition.
- Also keeps frame and missed-frame statistics for the housekeeping words.

---
 rtl/acq_frame_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/acq_frame_sequencer.sv
// acq_frame_sequencer: clear/integrate/readout frame scheduler with readout watchdog and frame stats.
// Define APES_EXT_SYNC_EN to hold each frame in SYNC_WAIT until an external sync pulse.
module acq_frame_sequencer #(
    parameter logic [31:0] INTEG_CYCLES   = 32'd50_000_000,
    parameter logic [7:0]  CLR_CYCLES     = 8'd4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd25_000_000
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rdout_done,
    input  logic        ext_sync,
    output logic        cnt_clr,
    output logic        cnt_start,
    output logic        collect_done,
    output logic        en_rocket_rd,
    output logic        busy,
    output logic [2:0]  state,
    output logic [15:0] frame_cnt,
    output logic [7:0]  missed_cnt
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        INTEG     = 3'd2,
        WAIT_RD   = 3'd3,
        DONE      = 3'd4,
        SYNC_WAIT = 3'd5
    } state_t;

    state_t      state_q;
    logic [31:0] tmr_q;
    logic        cnt_clr_q, cnt_start_q, collect_done_q, en_rd_q, busy_q;
    logic [15:0] frame_q;
    logic [7:0]  missed_q;
    logic        clr_last, integ_last, wd_last;

    assign clr_last   = tmr_q == {24'd0, CLR_CYCLES} - 32'd1;
    assign integ_last = tmr_q == INTEG_CYCLES - 32'd1;
    assign wd_last    = tmr_q == TIMEOUT_CYCLES - 32'd1;

`ifndef APES_EXT_SYNC_EN
    logic ext_sync_unused;
    assign ext_sync_unused = ext_sync;
`endif

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            cnt_clr_q      <= 1'b0;
            cnt_start_q    <= 1'b0;
            collect_done_q <= 1'b0;
            en_rd_q        <= 1'b0;
            busy_q         <= 1'b0;
            frame_q        <= '0;
            missed_q       <= '0;
        end else begin
            collect_done_q <= 1'b0;
            case (state_q)
                IDLE: if (enable) begin
                    state_q   <= CLEAR;
                    cnt_clr_q <= 1'b1;
                    busy_q    <= 1'b1;
                    tmr_q     <= '0;
                end
                CLEAR: if (clr_last) begin
                    cnt_clr_q <= 1'b0;
                    tmr_q     <= '0;
`ifdef APES_EXT_SYNC_EN
                    state_q   <= SYNC_WAIT;
`else
                    state_q     <= INTEG;
                    cnt_start_q <= 1'b1;
`endif
                end else tmr_q <= tmr_q + 32'd1;
`ifdef APES_EXT_SYNC_EN
                SYNC_WAIT: if (!enable) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else if (ext_sync) begin
                    state_q     <= INTEG;
                    cnt_start_q <= 1'b1;
                end
`endif
                INTEG: if (!enable) begin
                    state_q     <= IDLE;
                    cnt_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                end else if (integ_last) begin
                    state_q        <= WAIT_RD;
                    cnt_start_q    <= 1'b0;
                    collect_done_q <= 1'b1;
                end else tmr_q <= tmr_q + 32'd1;
                // first WAIT_RD cycle is the collect_done cycle; the watchdog arms after it
                WAIT_RD: if (!en_rd_q) begin
                    en_rd_q <= 1'b1;
                    tmr_q   <= '0;
                end else if (rdout_done) begin
                    state_q <= DONE;
                    en_rd_q <= 1'b0;
                    frame_q <= frame_q + 16'd1;
                end else if (wd_last) begin
                    en_rd_q   <= 1'b0;
                    missed_q  <= missed_q + {7'd0, missed_q != 8'hFF};
                    state_q   <= enable ? CLEAR : IDLE;
                    cnt_clr_q <= enable;
                    busy_q    <= enable;
                    tmr_q     <= '0;
                end else tmr_q <= tmr_q + 32'd1;
                DONE: begin
                    state_q   <= enable ? CLEAR : IDLE;
                    cnt_clr_q <= enable;
                    busy_q    <= enable;
                    tmr_q     <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_clr_q   <= 1'b0;
                    cnt_start_q <= 1'b0;
                    en_rd_q     <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign cnt_clr      = cnt_clr_q;
    assign cnt_start    = cnt_start_q;
    assign collect_done = collect_done_q;
    assign en_rocket_rd = en_rd_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_q;
    assign missed_cnt   = missed_q;
endmodule
